ob_mk_table_acc: RTL and testbench

OB_MK_TABLE_ACC -- requirements
Module: ob_mk_table_acc

---
 rtl/ob_mk_table_acc_if.sv | 33 +++
 rtl/ob_mk_table_acc.sv | 117 +++++++++++
 tb/tb_ob_mk_table_acc.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ob_mk_table_acc_if.sv
// Command/table/response bundle for the table accumulator.
// Handshakes: a transfer happens on a rising clk edge where vld & rdy are both high;
// vld is held until that edge and the payload stays stable while vld is high.
interface ob_mk_table_acc_if #(
  parameter int N     = 16,
  parameter int Q_W   = 10,
  parameter int ACC_W = 16,
  parameter int RND_W = 2
);
  logic                      cmd_vld;
  logic                      cmd_rdy;
  logic                      cmd_mode;
  logic                      cmd_goal_en;
  logic [ACC_W-1:0]          cmd_goal;
  logic [N-1:0][Q_W-1:0]     tbl_quantity_r;
  logic [N-1:0]              tbl_vld_r;
  logic                      rsp_vld;
  logic                      rsp_rdy;
  logic [ACC_W-1:0]          rsp_quantity;
  logic                      rsp_goal_met;
  logic [RND_W-1:0]          rsp_rounds;
  logic                      busy;

  modport master (
    output cmd_vld, cmd_mode, cmd_goal_en, cmd_goal, tbl_quantity_r, tbl_vld_r, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_quantity, rsp_goal_met, rsp_rounds, busy
  );

  modport slave (
    input  cmd_vld, cmd_mode, cmd_goal_en, cmd_goal, tbl_quantity_r, tbl_vld_r, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_quantity, rsp_goal_met, rsp_rounds, busy
  );
endinterface

// File: rtl/ob_mk_table_acc.sv
// Walks the table from the top index downward LANES_N entries per cycle, summing
// quantities (or counting valid entries) with saturation and optional goal-based early exit.
module ob_mk_table_acc #(
  parameter int N        = 16,
  parameter int LANES_N  = 6,
  parameter int Q_W      = 10,
  parameter int ACC_W    = 16,
  localparam int ROUNDS_N = (N + LANES_N - 1) / LANES_N,
  localparam int RND_W    = $clog2(ROUNDS_N + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ob_mk_table_acc_if.slave     bus,
  output logic [1:0]           dbg_state
);

  localparam int SUM_W = Q_W + $clog2(LANES_N + 1);
  localparam int EXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_RSP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [RND_W-1:0]   rnd_q;
  logic               mode_q;
  logic               goal_en_q;
  logic [ACC_W-1:0]   goal_q;

  logic [SUM_W-1:0]   round_sum;
  logic               round_inv;
  logic [EXT_W-1:0]   acc_ext;
  logic               goal_hit;
  logic               last_round;

  // Lane window for the current round; indices below zero simply never match.
  always_comb begin
    int hi;
    int lo;
    round_sum = '0;
    round_inv = 1'b0;
    hi = N - 1 - int'(rnd_q) * LANES_N;
    lo = hi - LANES_N + 1;
    for (int i = 0; i < N; i++) begin
      if ((i <= hi) && (i >= lo)) begin
        if (bus.tbl_vld_r[i]) begin
          round_sum = round_sum + (mode_q ? SUM_W'(1) : SUM_W'(bus.tbl_quantity_r[i]));
        end else begin
          round_inv = 1'b1;
        end
      end
    end
  end

  always_comb begin
    acc_ext = EXT_W'(acc_q) + EXT_W'(round_sum);
    if (acc_ext > EXT_W'({ACC_W{1'b1}})) begin
      acc_d = '1;
    end else begin
      acc_d = acc_ext[ACC_W-1:0];
    end
    goal_hit   = goal_en_q && (acc_d >= goal_q);
    last_round = (rnd_q == RND_W'(ROUNDS_N - 1)) || round_inv || goal_hit;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.cmd_vld) state_d = S_ACCUM;
      S_ACCUM: if (last_round)  state_d = S_RSP;
      S_RSP:   if (bus.rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      rnd_q     <= '0;
      mode_q    <= 1'b0;
      goal_en_q <= 1'b0;
      goal_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_vld) begin
            mode_q    <= bus.cmd_mode;
            goal_en_q <= bus.cmd_goal_en;
            goal_q    <= bus.cmd_goal;
            acc_q     <= '0;
            rnd_q     <= '0;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          rnd_q <= rnd_q + RND_W'(1);
        end
        default: ;
      endcase
    end
  end

  // acc/rnd only move in ACCUM, so the response fields hold through RSP.
  assign bus.cmd_rdy      = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.rsp_vld      = (state_q == S_RSP);
  assign bus.rsp_quantity = acc_q;
  assign bus.rsp_rounds   = rnd_q;
  assign bus.rsp_goal_met = goal_en_q && (acc_q >= goal_q);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ob_mk_table_acc.sv
// Bench for ob_mk_table_acc: scoreboarded commands on the default build plus a
// narrow-accumulator instance for saturation.
module tb_ob_mk_table_acc;
  localparam int N        = 16;
  localparam int LANES_N  = 6;
  localparam int Q_W      = 10;
  localparam int ACC_W    = 16;
  localparam int ROUNDS_N = 3;
  localparam int RND_W    = 2;
  localparam int SAT_W    = 10;
  localparam int EXP_W    = 8 + RND_W + 1 + ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_s;

  logic [N-1:0][Q_W-1:0] qty;
  logic [N-1:0]          vld;
  logic [N-1:0][Q_W-1:0] qty_s;
  logic [N-1:0]          vld_s;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  ob_mk_table_acc_if #(.N(N), .Q_W(Q_W), .ACC_W(ACC_W), .RND_W(RND_W)) bus ();
  ob_mk_table_acc_if #(.N(N), .Q_W(Q_W), .ACC_W(SAT_W), .RND_W(RND_W)) bus_s ();

  assign bus.tbl_quantity_r   = qty;
  assign bus.tbl_vld_r        = vld;
  assign bus_s.tbl_quantity_r = qty_s;
  assign bus_s.tbl_vld_r      = vld_s;

  ob_mk_table_acc #(.N(N), .LANES_N(LANES_N), .Q_W(Q_W), .ACC_W(ACC_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  ob_mk_table_acc #(.N(N), .LANES_N(LANES_N), .Q_W(Q_W), .ACC_W(SAT_W)) u_dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_s),
    .dbg_state (dbg_state_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: {latency, rounds, goal_met, quantity} for one command.
  function automatic logic [EXP_W-1:0] model(input logic mode, input logic goal_en,
                                             input logic [ACC_W-1:0] goal,
                                             input logic [N-1:0][Q_W-1:0] t_qty,
                                             input logic [N-1:0] t_vld);
    int acc;
    int k;
    int idx;
    logic inv;
    logic met;
    acc = 0;
    k = 0;
    for (int r = 0; r < ROUNDS_N; r++) begin
      inv = 1'b0;
      for (int j = 0; j < LANES_N; j++) begin
        idx = N - 1 - r * LANES_N - j;
        if (idx >= 0) begin
          if (t_vld[idx]) acc = acc + (mode ? 1 : int'(t_qty[idx]));
          else inv = 1'b1;
        end
      end
      if (acc > 65535) acc = 65535;
      k = r + 1;
      if (inv || (goal_en && (acc >= int'(goal)))) break;
    end
    met = goal_en && (acc >= int'(goal));
    return {8'(k + 1), RND_W'(k), met, ACC_W'(acc)};
  endfunction

  // ---------------- drivers ----------------
  task automatic set_valid_count(input int c);
    for (int i = 0; i < N; i++) vld[i] = (i >= N - c);
  endtask

  task automatic run_cmd(input string tag, input logic mode, input logic goal_en,
                         input logic [ACC_W-1:0] goal, input int hold,
                         output logic [ACC_W-1:0] q_obs, output logic [RND_W-1:0] rnd_obs,
                         output logic met_obs);
    logic [EXP_W-1:0] exp;
    int cyc;
    exp_q.push_back(model(mode, goal_en, goal, qty, vld));
    cyc = 0;
    @(negedge clk);
    while (!bus.cmd_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_idle"}, 32'(bus.cmd_rdy), 32'd1);
    bus.cmd_vld     = 1'b1;
    bus.cmd_mode    = mode;
    bus.cmd_goal_en = goal_en;
    bus.cmd_goal    = goal;
    @(posedge clk);
    #1 bus.cmd_vld = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_vld && cyc < 40);
    q_obs   = bus.rsp_quantity;
    rnd_obs = bus.rsp_rounds;
    met_obs = bus.rsp_goal_met;
    for (int h = 0; h < hold; h++) begin
      bus.cmd_vld = 1'b1;
      @(negedge clk);
      check({tag, "_hold_vld"}, 32'(bus.rsp_vld), 32'd1);
      check({tag, "_hold_rdy"}, 32'(bus.cmd_rdy), 32'd0);
      check({tag, "_hold_state"}, 32'(dbg_state), 32'd2);
      check({tag, "_hold_qty"}, 32'(bus.rsp_quantity), 32'(q_obs));
      check({tag, "_hold_rnd"}, 32'(bus.rsp_rounds), 32'(rnd_obs));
      check({tag, "_hold_met"}, 32'(bus.rsp_goal_met), 32'(met_obs));
    end
    bus.cmd_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    @(posedge clk);
    #1 bus.rsp_rdy = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, 32'(bus.cmd_rdy), 32'd1);
    check({tag, "_rsp_drop"}, 32'(bus.rsp_vld), 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_qty"}, 32'(q_obs), 32'(exp[ACC_W-1:0]));
    check({tag, "_met"}, 32'(met_obs), 32'(exp[ACC_W]));
    check({tag, "_rounds"}, 32'(rnd_obs), 32'(exp[ACC_W+RND_W:ACC_W+1]));
    check({tag, "_latency"}, 32'(cyc), 32'(exp[EXP_W-1:EXP_W-8]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ACC_W-1:0] q;
    logic [RND_W-1:0] rn;
    logic             met;
    logic             m;
    logic             ge;
    logic [ACC_W-1:0] g;
    int               cyc;

    bus.cmd_vld = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_goal_en = 1'b0; bus.cmd_goal = '0;
    bus.rsp_rdy = 1'b0;
    bus_s.cmd_vld = 1'b0; bus_s.cmd_mode = 1'b0; bus_s.cmd_goal_en = 1'b0; bus_s.cmd_goal = '0;
    bus_s.rsp_rdy = 1'b0;
    qty = '0; vld = '0; qty_s = '0; vld_s = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_qty", 32'(bus.rsp_quantity), 32'd0);
    check("rst_met", 32'(bus.rsp_goal_met), 32'd0);
    check("rst_rounds", 32'(bus.rsp_rounds), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Full table, quantities 1..16
    for (int i = 0; i < N; i++) qty[i] = Q_W'(i + 1);
    set_valid_count(16);
    run_cmd("full_sum", 1'b0, 1'b0, '0, 0, q, rn, met);
    check("full_sum_136", 32'(q), 32'd136);
    check("full_sum_r3", 32'(rn), 32'd3);

    // Top 8 valid, count mode: stops on the invalid lane in round 1
    for (int i = 0; i < N; i++) qty[i] = Q_W'(100);
    set_valid_count(8);
    run_cmd("count8", 1'b1, 1'b0, '0, 0, q, rn, met);
    check("count8_8", 32'(q), 32'd8);
    check("count8_r2", 32'(rn), 32'd2);

    // Goal reached after the first round
    for (int i = 0; i < N; i++) qty[i] = Q_W'(50);
    set_valid_count(16);
    run_cmd("goal250", 1'b0, 1'b1, 16'd250, 0, q, rn, met);
    check("goal250_300", 32'(q), 32'd300);
    check("goal250_met", 32'(met), 32'd1);
    check("goal250_r1", 32'(rn), 32'd1);

    run_cmd("goal0", 1'b0, 1'b1, 16'd0, 0, q, rn, met);
    check("goal0_met", 32'(met), 32'd1);
    check("goal0_r1", 32'(rn), 32'd1);

    run_cmd("goal_miss", 1'b0, 1'b1, 16'd900, 0, q, rn, met);
    check("goal_miss_met", 32'(met), 32'd0);
    check("goal_miss_800", 32'(q), 32'd800);

    set_valid_count(0);
    run_cmd("none_valid", 1'b0, 1'b0, '0, 0, q, rn, met);
    check("none_valid_0", 32'(q), 32'd0);
    check("none_valid_r1", 32'(rn), 32'd1);

    // Response back-pressure with commands offered while busy
    for (int i = 0; i < N; i++) qty[i] = Q_W'(3 * i + 7);
    set_valid_count(13);
    run_cmd("hold", 1'b0, 1'b0, '0, 5, q, rn, met);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) qty[i] = Q_W'($urandom_range(0, 1023));
      set_valid_count($urandom_range(0, 16));
      m  = 1'($urandom_range(0, 1));
      ge = 1'($urandom_range(0, 1));
      g  = m ? ACC_W'($urandom_range(0, 16)) : ACC_W'($urandom_range(0, 12000));
      run_cmd("rand", m, ge, g, $urandom_range(0, 2), q, rn, met);
    end

    // Reset during round 1 discards the operation
    for (int i = 0; i < N; i++) qty[i] = Q_W'(i + 1);
    set_valid_count(16);
    @(negedge clk);
    bus.cmd_vld = 1'b1; bus.cmd_mode = 1'b0; bus.cmd_goal_en = 1'b0; bus.cmd_goal = '0;
    @(posedge clk);
    #1 bus.cmd_vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("midrst_qty", 32'(bus.rsp_quantity), 32'd0);
    check("midrst_rounds", 32'(bus.rsp_rounds), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", 32'(bus.rsp_vld), 32'd0);
    run_cmd("after_rst", 1'b0, 1'b0, '0, 0, q, rn, met);
    check("after_rst_136", 32'(q), 32'd136);

    // Narrow accumulator saturates instead of wrapping
    for (int i = 0; i < N; i++) qty_s[i] = Q_W'(1000);
    vld_s = '1;
    @(negedge clk);
    bus_s.cmd_vld = 1'b1;
    @(posedge clk);
    #1 bus_s.cmd_vld = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_s.rsp_vld && cyc < 40);
    check("sat_qty", 32'(bus_s.rsp_quantity), 32'd1023);
    check("sat_rounds", 32'(bus_s.rsp_rounds), 32'd3);
    check("sat_latency", 32'(cyc), 32'd4);
    bus_s.rsp_rdy = 1'b1;
    @(posedge clk);
    #1 bus_s.rsp_rdy = 1'b0;
    @(negedge clk);
    check("sat_idle", 32'(bus_s.cmd_rdy), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
